// File: rtl/frogger_move_input.sv
// Frogger move-input conditioner: turns four raw, bouncy, asynchronous
// direction buttons into clean one-cycle move pulses. Each button is
// synchronised and debounced, then press-edge detected. One arbiter
// owns a single direction at a time and can optionally auto-repeat it.
module frogger_move_input #(
    parameter int c_DEBOUNCE_LIMIT = 250000,
    parameter int c_REPEAT_EN      = 1,
    parameter int c_REPEAT_DELAY   = 12500000,
    parameter int c_REPEAT_RATE    = 5000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic       i_Enable,
    input  logic       i_Up_Btn,
    input  logic       i_Down_Btn,
    input  logic       i_Left_Btn,
    input  logic       i_Right_Btn,
    output logic       o_Up_Mvt,
    output logic       o_Down_Mvt,
    output logic       o_Left_Mvt,
    output logic       o_Right_Mvt,
    output logic       o_Held,
    output logic [1:0] o_Last_Dir
);

    localparam int c_DB_W    = $clog2(c_DEBOUNCE_LIMIT);
    localparam int c_TMR_MAX = (c_REPEAT_DELAY > c_REPEAT_RATE) ? c_REPEAT_DELAY : c_REPEAT_RATE;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(c_DEBOUNCE_LIMIT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_DELAY = c_TMR_W'(c_REPEAT_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_RATE  = c_TMR_W'(c_REPEAT_RATE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit index doubles as the direction code: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]        btn_s;
    logic [3:0]        sync1_r;
    logic [3:0]        sync2_r;
    logic [3:0]        deb_r;
    logic [3:0]        deb_d_r;
    logic [c_DB_W-1:0] cnt_r [4];
    logic [3:0]        press_s;

    state_t             state_r;
    state_t             state_s;
    logic [1:0]         owner_r;
    logic [1:0]         owner_s;
    logic [c_TMR_W-1:0] timer_r;
    logic [c_TMR_W-1:0] timer_s;
    logic [3:0]         mvt_r;
    logic [3:0]         mvt_s;
    logic [1:0]         last_dir_r;
    logic [1:0]         last_dir_s;
    logic [1:0]         sel_s;

    assign btn_s   = {i_Right_Btn, i_Left_Btn, i_Down_Btn, i_Up_Btn};
    assign press_s = deb_r & ~deb_d_r;

    // Two-flop synchroniser for the asynchronous raw buttons.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: adopt the synchronised level only after it has differed
    // from the debounced state for c_DEBOUNCE_LIMIT consecutive cycles.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            deb_r   <= 4'b0000;
            deb_d_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= {c_DB_W{1'b0}};
            end
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (cnt_r[i] == c_DB_LAST) begin
                        deb_r[i] <= sync2_r[i];
                        cnt_r[i] <= {c_DB_W{1'b0}};
                    end else begin
                        cnt_r[i] <= cnt_r[i] + c_DB_W'(1);
                    end
                end else begin
                    cnt_r[i] <= {c_DB_W{1'b0}};
                end
            end
        end
    end

    // Fixed-priority pick among simultaneous presses: up > down > left > right.
    always_comb begin
        sel_s = 2'd3;
        if (press_s[0]) begin
            sel_s = 2'd0;
        end else if (press_s[1]) begin
            sel_s = 2'd1;
        end else if (press_s[2]) begin
            sel_s = 2'd2;
        end else begin
            sel_s = 2'd3;
        end
    end

    // Arbiter next state: grant one owner per press, repeat while held,
    // and drop everything while the game is not accepting moves.
    always_comb begin
        state_s    = state_r;
        owner_s    = owner_r;
        timer_s    = timer_r;
        mvt_s      = 4'b0000;
        last_dir_s = last_dir_r;
        if (!i_Enable) begin
            state_s = IDLE;
            timer_s = {c_TMR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_s != 4'b0000) begin
                        mvt_s[sel_s] = 1'b1;
                        owner_s      = sel_s;
                        last_dir_s   = sel_s;
                        timer_s      = c_TMR_DELAY;
                        state_s      = HOLD;
                    end else begin
                        state_s = IDLE;
                    end
                end
                HOLD: begin
                    // Release wins over a repeat that falls due on the same cycle.
                    if (!deb_r[owner_r]) begin
                        state_s = IDLE;
                        timer_s = {c_TMR_W{1'b0}};
                    end else if (c_REPEAT_EN != 0) begin
                        if (timer_r != {c_TMR_W{1'b0}}) begin
                            timer_s = timer_r - c_TMR_W'(1);
                        end else begin
                            mvt_s[owner_r] = 1'b1;
                            timer_s        = c_TMR_RATE;
                        end
                    end else begin
                        state_s = HOLD;
                    end
                end
                default: begin
                    state_s = IDLE;
                    timer_s = {c_TMR_W{1'b0}};
                end
            endcase
        end
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_r    <= IDLE;
            owner_r    <= 2'd0;
            timer_r    <= {c_TMR_W{1'b0}};
            mvt_r      <= 4'b0000;
            last_dir_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            timer_r    <= timer_s;
            mvt_r      <= mvt_s;
            last_dir_r <= last_dir_s;
        end
    end

    assign o_Up_Mvt    = mvt_r[0];
    assign o_Down_Mvt  = mvt_r[1];
    assign o_Left_Mvt  = mvt_r[2];
    assign o_Right_Mvt = mvt_r[3];
    assign o_Held      = (state_r == HOLD);
    assign o_Last_Dir  = last_dir_r;

endmodule

// File: doc/frogger_move_input.md
Name: frogger_move_input

Overview:
- Upstream input conditioner for the frog movement controller. It converts the four raw, bouncy, asynchronous direction buttons into clean single-cycle move pulses.
- Four stages per button:
  - two-flop synchroniser;
  - per-button debounce counter;
  - press-edge detection;
  - one-direction-at-a-time arbiter with optional hold-to-repeat.
- Outputs drive the movement controller's up/down/left/right move inputs directly. At most one move pulse is ever active per cycle.

Parameters:
- c_DEBOUNCE_LIMIT, 250000: consecutive cycles a synchronised level must persist before the debounced state adopts it (≥2).
- c_REPEAT_EN, 1: 1 = holding a button auto-repeats moves; 0 = one pulse per press.
- c_REPEAT_DELAY, 12500000: cycles from the first pulse to the first repeat pulse (≥1).
- c_REPEAT_RATE, 5000000: cycles between subsequent repeat pulses (≥1).

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock)
- i_Rst_N  in  1  asynchronous active-low reset
- i_Enable  in  1  1 = game accepting moves; 0 = suppress all pulses
- i_Up_Btn  in  1  raw button, active-high, asynchronous
- i_Down_Btn  in  1  raw button, active-high, asynchronous
- i_Left_Btn  in  1  raw button, active-high, asynchronous
- i_Right_Btn  in  1  raw button, active-high, asynchronous
- o_Up_Mvt  out  1  one-cycle move pulse
- o_Down_Mvt  out  1  one-cycle move pulse
- o_Left_Mvt  out  1  one-cycle move pulse
- o_Right_Mvt  out  1  one-cycle move pulse
- o_Held  out  1  arbiter in HOLD (a direction is owned)
- o_Last_Dir  out  2  last issued direction: 0 up, 1 down, 2 left, 3 right

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is asynchronous, active-low on i_Rst_N, and clears everything below:
  - sync flops, debounced states and debounce counters → 0;
  - FSM → IDLE, repeat timer → 0;
  - all o_*_Mvt → 0, o_Held → 0, o_Last_Dir → 0.
- Synchroniser: two flops per button. The debounce stage sees only the second flop.
- Debounce:
  - Counter width is $clog2(c_DEBOUNCE_LIMIT).
  - When the synchronised level differs from the debounced state, the counter increments.
  - When the counter reaches c_DEBOUNCE_LIMIT-1 while still differing, the debounced state flips and the counter clears.
  - When the synchronised level equals the debounced state, the counter clears. Any glitch shorter than c_DEBOUNCE_LIMIT cycles is therefore rejected.
- Press event: debounced state 0→1, one cycle wide, per button.
- Arbiter FSM, IDLE:
  - On any press event with i_Enable=1, select the highest-priority pressing button: Up > Down > Left > Right.
  - Registered outputs take effect on the next clock edge: pulse that direction's o_*_Mvt for exactly one cycle, latch the owner, set o_Last_Dir, load the timer with c_REPEAT_DELAY-1, and go to HOLD.
  - Press events of lower-priority buttons in the same cycle are discarded.
- Arbiter FSM, HOLD:
  - Owner's debounced state = 0 → IDLE, no pulse. This is checked before the timer.
  - Else if c_REPEAT_EN=1:
    - timer ≠ 0: decrement.
    - timer = 0: pulse the owner for one cycle and reload c_REPEAT_RATE-1.
  - Else (c_REPEAT_EN=0): no further pulses; hold until release.
  - Press events from non-owner buttons are ignored and never queued. After the owner releases, a still-held other button does NOT move until it is released and pressed again.
- i_Enable=0: in either state, the FSM is forced to IDLE on the next edge, any pending pulse is suppressed, and the timer clears. Debounce and synchronisers keep running. A button already held when i_Enable rises produces no pulse until re-pressed.
- Latency: a clean raw edge is first sampled at edge 0. The debounced state flips at edge c_DEBOUNCE_LIMIT+1, and the move pulse is high during the cycle after edge c_DEBOUNCE_LIMIT+2.
- Invariants:
  - o_Up_Mvt+o_Down_Mvt+o_Left_Mvt+o_Right_Mvt ≤ 1 every cycle.
  - Pulses are never wider than one cycle.
  - Consecutive pulses are separated by ≥ min(c_REPEAT_DELAY, c_REPEAT_RATE) cycles, or by a debounced release/press sequence.
- Reset mid-HOLD: outputs drop immediately (asynchronous). After i_Rst_N deasserts, a still-held button is seen as a fresh press once it is debounced.

Test Plan:
- Bench parameters throughout: c_DEBOUNCE_LIMIT=4, c_REPEAT_DELAY=10, c_REPEAT_RATE=5, c_REPEAT_EN=1, i_Enable=1.
- Clean press, single pulse: hold i_Up_Btn high for 8 cycles, then low → exactly one o_Up_Mvt pulse, high in cycle 7 after first sampling (edge 6 + 1); o_Last_Dir=0; o_Held high from the pulse until 5 cycles after release.
- Bounce rejection: i_Left_Btn toggles high 3 cycles / low 1 cycle ×5, then steady high 20 cycles → no pulse during the bounces, exactly one o_Left_Mvt pulse after the steady period debounces (repeat then at +10).
- Auto-repeat: hold i_Right_Btn for 40 cycles past debounce → o_Right_Mvt pulses at relative cycles 0, 10, 15, 20, 25, 30, 35, and none after release. With c_REPEAT_EN=0 → only the cycle-0 pulse.
- Simultaneous press and non-queueing: assert i_Down_Btn and i_Right_Btn on the same edge, hold both, then release Down → only o_Down_Mvt pulses and repeats; after Down's release, no o_Right_Mvt until Right is released and re-pressed.
- Enable gating: hold i_Up_Btn with i_Enable=0 for 30 cycles → no pulses. Raise i_Enable with Up still held → still no pulse. Release and re-press Up → one pulse. Drop i_Enable in HOLD 3 cycles before a repeat is due → the repeat is suppressed and o_Held=0.
- Async reset: assert i_Rst_N=0 mid-HOLD between clock edges → all outputs 0 immediately. Release reset with Up still held → one o_Up_Mvt pulse after the debounce latency; o_Last_Dir=0.
